dmem_imem_arbiter: RTL and testbench

- Shares one non-pipelined memory port between the instruction-fetch requester (I) and the data-memory requester (D).
- Sits between the fetch/writeback stages and the memory (or cache) interface.
- Captures one-cycle request pulses from each side, serializes them with round-robin priority, and routes each single-cycle response back to the requester that owns the outstanding transaction.
- At most one downstream transaction is outstanding at any time.

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/mem_req_slot.sv | 35 +++
 rtl/dmem_imem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_imem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory-port arbiter: FSM state, transaction owner and request record.
package mem_arb_pkg;

  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_MASK_W = PKG_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_MASK_W-1:0] rmask;
    logic [PKG_MASK_W-1:0] wmask;
    logic [PKG_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic req_active(input mem_req_t r);
    return (|r.rmask) | (|r.wmask);
  endfunction

  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One-entry pending buffer for a single requester: captures a request pulse, holds it until
// the arbiter issues it. A pulse arriving while full or while this requester is locked is dropped.
module mem_req_slot
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  mem_req_t req,
  input  logic     locked,
  input  logic     clear,
  output logic     full,
  output logic     drop,
  output mem_req_t entry
);

  logic valid;
  logic capture;

  assign valid   = req_active(req);
  assign capture = valid & ~full & ~locked;
  assign drop    = valid & (full | locked);

  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      entry <= '0;
    end else if (capture) begin
      full  <= 1'b1;
      entry <= req;
    end else if (clear) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_imem_arbiter.sv
// Shares one non-pipelined memory port between instruction fetch (I) and data (D) requesters.
// Round-robin between captured requests, one transaction outstanding, response routed to its owner.
module dmem_imem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = PKG_ADDR_W,
  parameter int DATA_W = PKG_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_rmask,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_rmask,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_rmask,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp,
  output logic                busy
);

  arb_state_t  state;
  arb_owner_t  grant;
  arb_owner_t  owner;
  arb_owner_t  last_grant;
  arb_owner_t  next_grant;
  mem_req_t    mem_q;
  mem_req_t    i_req, d_req;
  mem_req_t    i_entry, d_entry;
  logic        i_full, d_full;
  logic        i_drop, d_drop;
  logic        i_locked, d_locked;
  logic        i_clear, d_clear;
  logic        resp_ok;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  assign i_req = '{addr: i_addr, rmask: i_rmask, wmask: '0, wdata: '0};
  assign d_req = '{addr: d_addr, rmask: d_rmask, wmask: d_wmask, wdata: d_wdata};

  // Only a response seen in WAIT belongs to a transaction; anything else is stale or spurious.
  assign resp_ok = (state == WAIT) & mem_resp;

  // The owner may post its next request in the same cycle its response arrives.
  assign i_locked = (state == WAIT) & (owner == OWN_I) & ~mem_resp;
  assign d_locked = (state == WAIT) & (owner == OWN_D) & ~mem_resp;

  assign i_clear = (state == ISSUE) & (grant == OWN_I);
  assign d_clear = (state == ISSUE) & (grant == OWN_D);

  mem_req_slot u_i_slot (
    .clk    (clk),
    .rst    (rst),
    .req    (i_req),
    .locked (i_locked),
    .clear  (i_clear),
    .full   (i_full),
    .drop   (i_drop),
    .entry  (i_entry)
  );

  mem_req_slot u_d_slot (
    .clk    (clk),
    .rst    (rst),
    .req    (d_req),
    .locked (d_locked),
    .clear  (d_clear),
    .full   (d_full),
    .drop   (d_drop),
    .entry  (d_entry)
  );

  always_comb begin
    next_grant = OWN_I;
    if (i_full && d_full) begin
      next_grant = other_owner(last_grant);
    end else if (d_full) begin
      next_grant = OWN_D;
    end
  end

  // mem_q is loaded at grant time so the downstream pulse is a clean register output in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= OWN_I;
      owner      <= OWN_I;
      last_grant <= OWN_I;
      mem_q      <= '0;
    end else begin
      mem_q <= '0;
      case (state)
        IDLE: begin
          if (i_full || d_full) begin
            grant <= next_grant;
            mem_q <= (next_grant == OWN_D) ? d_entry : i_entry;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          owner      <= grant;
          last_grant <= grant;
          state      <= WAIT;
        end
        WAIT: begin
          if (mem_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (resp_ok) begin
      if (owner == OWN_I) begin
        i_rdata_q <= mem_rdata;
      end else begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign i_resp  = resp_ok & (owner == OWN_I);
  assign d_resp  = resp_ok & (owner == OWN_D);
  assign i_rdata = i_resp ? mem_rdata : i_rdata_q;
  assign d_rdata = d_resp ? mem_rdata : d_rdata_q;

  assign mem_addr  = mem_q.addr;
  assign mem_rmask = mem_q.rmask;
  assign mem_wmask = mem_q.wmask;
  assign mem_wdata = mem_q.wdata;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!i_drop)
        else $warning("dmem_imem_arbiter: I request dropped (slot full or transaction outstanding)");
      assert (!d_drop)
        else $warning("dmem_imem_arbiter: D request dropped (slot full or transaction outstanding)");
    end
  end

endmodule

// File: tb/tb_dmem_imem_arbiter.sv
// Bench for dmem_imem_arbiter: directed cycle vectors for the corner cases, then randomized
// traffic compared against a transaction-level timing model.
module tb_dmem_imem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  i_rmask, d_rmask, d_wmask;
  logic        mem_resp;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        i_resp, d_resp, busy;

  dmem_imem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rmask(i_rmask), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst;
    logic [31:0] i_addr;  logic [3:0] i_rmask;
    logic [31:0] d_addr;  logic [3:0] d_rmask; logic [3:0] d_wmask; logic [31:0] d_wdata;
    logic        mem_resp; logic [31:0] mem_rdata;
    logic [31:0] e_addr;  logic [3:0] e_rmask; logic [3:0] e_wmask; logic [31:0] e_wdata;
    logic        e_busy;
    logic        e_iresp; logic [31:0] e_irdata;
    logic        e_dresp; logic [31:0] e_drdata;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] R2 = 32'h12345678;
  localparam logic [31:0] CF = 32'hCAFEF00D;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic [31:0] ia, input logic [3:0] irm,
      input logic [31:0] da, input logic [3:0] drm, input logic [3:0] dwm, input logic [31:0] dwd,
      input logic mr, input logic [31:0] mrd,
      input logic [31:0] ea, input logic [3:0] erm, input logic [3:0] ewm, input logic [31:0] ewd,
      input logic eb, input logic eir, input logic [31:0] eird, input logic edr, input logic [31:0] edrd);
    vec_t v;
    v.rst = 1'b0;
    v.i_addr = ia; v.i_rmask = irm;
    v.d_addr = da; v.d_rmask = drm; v.d_wmask = dwm; v.d_wdata = dwd;
    v.mem_resp = mr; v.mem_rdata = mrd;
    v.e_addr = ea; v.e_rmask = erm; v.e_wmask = ewm; v.e_wdata = ewd;
    v.e_busy = eb; v.e_iresp = eir; v.e_irdata = eird; v.e_dresp = edr; v.e_drdata = edrd;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    @(posedge clk); #1;
    rst = v.rst;
    i_addr = v.i_addr; i_rmask = v.i_rmask;
    d_addr = v.d_addr; d_rmask = v.d_rmask; d_wmask = v.d_wmask; d_wdata = v.d_wdata;
    mem_resp = v.mem_resp; mem_rdata = v.mem_rdata;
    @(negedge clk);
    check({tag, ".mem"}, 96'({mem_addr, mem_rmask, mem_wmask, mem_wdata}),
          96'({v.e_addr, v.e_rmask, v.e_wmask, v.e_wdata}));
    check({tag, ".busy"}, 96'(busy), 96'(v.e_busy));
    check({tag, ".i_resp"}, 96'(i_resp), 96'(v.e_iresp));
    check({tag, ".d_resp"}, 96'(d_resp), 96'(v.e_dresp));
    check({tag, ".i_rdata"}, 96'(i_rdata), 96'(v.e_irdata));
    check({tag, ".d_rdata"}, 96'(d_rdata), 96'(v.e_drdata));
  endtask

  // Random-phase model: per-requester pending record plus timestamps of the current transaction.
  bit          m_pv[2];
  mem_req_t    m_pr[2];
  logic [31:0] m_rd[2];
  bit          m_infl;
  int          m_who, m_last, m_issue, m_resp_at, m_idle_at;
  mem_req_t    m_cur;

  initial begin
    vec_t v;
    rst = 1'b1;
    i_addr = '0; i_rmask = '0; d_addr = '0; d_rmask = '0; d_wmask = '0; d_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.mem", 96'({mem_addr, mem_rmask, mem_wmask, mem_wdata}), 96'd0);
    check("reset.busy", 96'(busy), 96'd0);
    check("reset.resp", 96'({i_resp, d_resp}), 96'd0);
    check("reset.rdata", 96'({i_rdata, d_rdata}), 96'd0);

    // ia irm | da drm dwm dwd | mr mrd | ea erm ewm ewd | eb eir eird edr edrd
    tbl.push_back(mk('h1000,'hF, 0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 'h1000,'hF,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 1,DB, 0,0,0,0, 1,1,DB,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,DB,0,0));
    tbl.push_back(mk('h2000,'hF, 'h3000,0,'h3,'hABCD, 0,0, 0,0,0,0, 0,0,DB,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,DB,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 'h3000,0,'h3,'hABCD, 1,0,DB,0,0));
    tbl.push_back(mk(0,0, 'h4000,'hF,0,0, 1,0, 0,0,0,0, 1,0,DB,1,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,DB,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 'h2000,'hF,0,0, 1,0,DB,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 1,R2, 0,0,0,0, 1,1,R2,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,R2,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 'h4000,'hF,0,0, 1,0,R2,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 1,CF, 0,0,0,0, 1,0,R2,1,CF));
    tbl.push_back(mk('h5003,'h1, 0,0,0,0, 0,0, 0,0,0,0, 0,0,R2,0,CF));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,R2,0,CF));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 'h5003,'h1,0,0, 1,0,R2,0,CF));
    tbl.push_back(mk(0,0, 'h6002,0,'hC,'h89AB0000, 1,'h55, 0,0,0,0, 1,1,'h55,0,CF));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,'h55,0,CF));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0, 'h6002,0,'hC,'h89AB0000, 1,0,'h55,0,CF));
    tbl.push_back(mk(0,0, 0,0,0,0, 1,'h77, 0,0,0,0, 1,0,'h55,1,'h77));
    tbl.push_back(mk(0,0, 0,0,0,0, 1,'h99, 0,0,0,0, 0,0,'h55,0,'h77));
    for (int k = 0; k < tbl.size(); k++) apply_vec(tbl[k], $sformatf("vec%0d", k));

    // Reset while D is outstanding and I is pending; a late response must be ignored.
    apply_vec(mk(0,0, 'h7000,'hF,0,0, 0,0, 0,0,0,0, 0,0,'h55,0,'h77), "rstw0");
    apply_vec(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,'h55,0,'h77), "rstw1");
    apply_vec(mk('h7100,'hF, 0,0,0,0, 0,0, 'h7000,'hF,0,0, 1,0,'h55,0,'h77), "rstw2");
    v = mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 1,0,'h55,0,'h77);
    v.rst = 1'b1;
    apply_vec(v, "rstw3");
    apply_vec(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0), "rstw4");
    apply_vec(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0), "rstw5");
    apply_vec(mk(0,0, 0,0,0,0, 1,'h1234, 0,0,0,0, 0,0,0,0,0), "rstw6");
    apply_vec(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0), "rstw7");
    apply_vec(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0), "rstw8");

    // Second I pulse while I is outstanding: dropped, so only one downstream read appears.
    apply_vec(mk('h8000,'hF, 0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0), "viol0");
    apply_vec(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0), "viol1");
    apply_vec(mk(0,0, 0,0,0,0, 0,0, 'h8000,'hF,0,0, 1,0,0,0,0), "viol2");
    apply_vec(mk('h8800,'hF, 0,0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0), "viol3");
    apply_vec(mk(0,0, 0,0,0,0, 1,'hAA, 0,0,0,0, 1,1,'hAA,0,0), "viol4");
    apply_vec(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,'hAA,0,0), "viol5");
    apply_vec(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,'hAA,0,0), "viol6");
    apply_vec(mk(0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,'hAA,0,0), "viol7");

    // Randomized traffic against the timing model.
    @(posedge clk); #1;
    rst = 1'b1; i_rmask = '0; d_rmask = '0; d_wmask = '0; mem_resp = 1'b0;
    m_pv = '{0, 0}; m_rd = '{32'd0, 32'd0}; m_infl = 0;
    m_who = 0; m_last = 0; m_issue = 0; m_resp_at = 0; m_idle_at = 0; m_cur = '0;
    for (int c = 0; c < 1500; c++) begin
      bit rst_now, wait_phase, resp_now, resp_ok;
      bit legal[2];
      bit req[2];
      logic [95:0] exp_mem;
      @(posedge clk); #1;
      rst_now    = ($urandom_range(0, 299) == 0);
      wait_phase = m_infl && (c > m_issue);
      resp_now   = wait_phase ? (c >= m_resp_at) : ($urandom_range(0, 15) == 0);
      resp_ok    = wait_phase && resp_now;
      for (int s = 0; s < 2; s++) begin
        legal[s] = !m_pv[s] && !(m_infl && m_who == s && !resp_ok);
        req[s]   = legal[s] && ($urandom_range(0, 2) == 0);
      end
      rst = rst_now;
      mem_resp = resp_now; mem_rdata = $urandom;
      i_addr = $urandom; i_rmask = req[0] ? 4'($urandom_range(1, 15)) : 4'd0;
      d_addr = $urandom; d_wdata = $urandom; d_rmask = 4'd0; d_wmask = 4'd0;
      if (req[1]) begin
        if ($urandom_range(0, 1) == 0) d_rmask = 4'($urandom_range(1, 15));
        else d_wmask = 4'($urandom_range(1, 15));
      end

      @(negedge clk);
      exp_mem = (m_infl && c == m_issue) ? 96'(m_cur) : 96'd0;
      check($sformatf("rnd%0d.mem", c), 96'({mem_addr, mem_rmask, mem_wmask, mem_wdata}), exp_mem);
      check($sformatf("rnd%0d.busy", c), 96'(busy), 96'(m_infl && c >= m_issue));
      check($sformatf("rnd%0d.resp", c), 96'({i_resp, d_resp}),
            96'({resp_ok && m_who == 0, resp_ok && m_who == 1}));
      check($sformatf("rnd%0d.i_rdata", c), 96'(i_rdata),
            96'((resp_ok && m_who == 0) ? mem_rdata : m_rd[0]));
      check($sformatf("rnd%0d.d_rdata", c), 96'(d_rdata),
            96'((resp_ok && m_who == 1) ? mem_rdata : m_rd[1]));

      if (rst_now) begin
        m_pv = '{0, 0}; m_rd = '{32'd0, 32'd0}; m_infl = 0; m_last = 0; m_idle_at = c + 1;
      end else begin
        if (resp_ok) begin
          m_infl = 0; m_idle_at = c + 1; m_rd[m_who] = mem_rdata;
        end
        if (!m_infl && c >= m_idle_at && (m_pv[0] || m_pv[1])) begin
          m_who = (m_pv[0] && m_pv[1]) ? 1 - m_last : (m_pv[1] ? 1 : 0);
          m_last = m_who; m_cur = m_pr[m_who]; m_pv[m_who] = 0;
          m_infl = 1; m_issue = c + 1; m_resp_at = c + 2 + int'($urandom_range(0, 3));
        end
        if (req[0]) begin
          m_pv[0] = 1; m_pr[0] = '{addr: i_addr, rmask: i_rmask, wmask: 4'd0, wdata: 32'd0};
        end
        if (req[1]) begin
          m_pv[1] = 1; m_pr[1] = '{addr: d_addr, rmask: d_rmask, wmask: d_wmask, wdata: d_wdata};
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
